// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a shared register bank: grants one of four
// requesters, latches its address/data and issues a single write-enable pulse.
module reg_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          REQ,
  input  logic [4*ADDR_W-1:0] ADDR_IN,
  input  logic [4*DATA_W-1:0] DATA_IN,
  output logic [3:0]          GNT,
  output logic                WE,
  output logic [ADDR_W-1:0]   WADDR,
  output logic [DATA_W-1:0]   WDATA,
  output logic                BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] owner;
  logic [1:0] winner;
  logic       found;
  logic [1:0] idx;

  // Rotating priority search starting just after the last served requester
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int k = 1; k <= 4; k++) begin
      idx    = last + 2'(k);
      winner = (!found && REQ[idx]) ? idx : winner;
      found  = found | REQ[idx];
    end
  end

  // Transaction sequencer; all outputs are registered here
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      last  <= 2'd3;
      owner <= 2'd0;
      GNT   <= 4'b0000;
      WE    <= 1'b0;
      WADDR <= '0;
      WDATA <= '0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ != 4'b0000) begin
            owner <= winner;
            GNT   <= 4'b0001 << winner;
            WADDR <= ADDR_IN[winner*ADDR_W +: ADDR_W];
            WDATA <= DATA_IN[winner*DATA_W +: DATA_W];
            WE    <= 1'b1;
            BUSY  <= 1'b1;
            state <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          WE    <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: begin
          // Hold the grant until the owner lets go; there is deliberately no timeout
          if (!REQ[owner]) begin
            GNT   <= 4'b0000;
            BUSY  <= 1'b0;
            last  <= owner;
            state <= IDLE;
          end else begin
            state <= RELEASE;
          end
        end
        default: begin
          GNT   <= 4'b0000;
          WE    <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter using immediate assertions.
module tb_reg_write_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [7:0]  ADDR_IN;
  logic [31:0] DATA_IN;
  logic [3:0]  GNT;
  logic        WE;
  logic [1:0]  WADDR;
  logic [7:0]  WDATA;
  logic        BUSY;

  int n_checks = 0;
  int n_fails  = 0;
  int we_total = 0;
  int we_mark  = 0;
  logic prev_we = 1'b0;
  logic we_back_to_back = 1'b0;
  logic [7:0] bank [4];

  reg_write_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
    .GNT(GNT), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Register-bank model plus WE pulse statistics
  always @(posedge CLK) if (WE) bank[WADDR] <= WDATA;
  always @(negedge CLK) begin
    if (WE) we_total++;
    if (WE && prev_we) we_back_to_back = 1'b1;
    prev_we = WE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
    ADDR_IN[i*2 +: 2] = a;
    DATA_IN[i*8 +: 8] = d;
  endtask

  initial begin
    RST = 1'b1; REQ = 4'b0000; ADDR_IN = 8'h00; DATA_IN = 32'h0;
    #1;
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_we", 32'(WE), 32'h0);
    chk("rst_waddr", 32'(WADDR), 32'h0);
    chk("rst_wdata", 32'(WDATA), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    tick();
    RST = 1'b0;

    // Single write from requester 0
    set_req(0, 2'd2, 8'hA5);
    REQ = 4'b0001;
    tick();
    chk("t1_gnt", 32'(GNT), 32'h1);
    chk("t1_we", 32'(WE), 32'h1);
    chk("t1_waddr", 32'(WADDR), 32'h2);
    chk("t1_wdata", 32'(WDATA), 32'hA5);
    chk("t1_busy", 32'(BUSY), 32'h1);
    tick();
    chk("t1_we_low", 32'(WE), 32'h0);
    chk("t1_gnt_hold", 32'(GNT), 32'h1);
    REQ = 4'b0000;
    tick();
    chk("t1_gnt_idle", 32'(GNT), 32'h0);
    chk("t1_busy_idle", 32'(BUSY), 32'h0);
    chk("t1_wdata_kept", 32'(WDATA), 32'hA5);
    chk("t1_bank", 32'(bank[2]), 32'hA5);

    // Round robin from reset with all four requesting
    RST = 1'b1; #1; RST = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'h10 + 8'(i));
    we_mark = we_total;
    REQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", 32'(GNT), 32'(4'b0001 << i));
      chk("rr_we", 32'(WE), 32'h1);
      chk("rr_wdata", 32'(WDATA), 32'h10 + 32'(i));
      tick();
      chk("rr_we_low", 32'(WE), 32'h0);
      REQ[i] = 1'b0;
      tick();
      chk("rr_release", 32'(GNT), 32'h0);
    end
    chk("rr_we_pulses", 32'(we_total - we_mark), 32'd4);

    // Serve 2, then 0101 must pick 0 before 2
    REQ = 4'b0100;
    tick();
    chk("p_gnt2", 32'(GNT), 32'h4);
    tick(); REQ = 4'b0000; tick();
    REQ = 4'b0101;
    tick();
    chk("p_gnt0", 32'(GNT), 32'h1);
    tick(); REQ = 4'b0100; tick();
    chk("p_idle", 32'(BUSY), 32'h0);
    tick();
    chk("p_gnt2b", 32'(GNT), 32'h4);
    tick(); REQ = 4'b0000; tick();

    // Asynchronous reset during WRITE
    REQ = 4'b0010;
    tick();
    chk("ar_we_before", 32'(WE), 32'h1);
    #1; RST = 1'b1; #1;
    chk("ar_we", 32'(WE), 32'h0);
    chk("ar_gnt", 32'(GNT), 32'h0);
    chk("ar_busy", 32'(BUSY), 32'h0);
    RST = 1'b0; REQ = 4'b0000;
    tick();
    chk("ar_no_we", 32'(WE), 32'h0);
    REQ = 4'b1000;
    tick();
    chk("ar_gnt3", 32'(GNT), 32'h8);
    tick(); REQ = 4'b0000; tick();

    // Owner holds REQ for 10 cycles while requester 3 waits
    REQ = 4'b1010;
    tick();
    chk("st_gnt1", 32'(GNT), 32'h2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("st_gnt", 32'(GNT), 32'h2);
      chk("st_we", 32'(WE), 32'h0);
    end
    REQ = 4'b1000;
    tick();
    chk("st_exit", 32'(GNT), 32'h0);
    tick();
    chk("st_gnt3", 32'(GNT), 32'h8);
    chk("st_we3", 32'(WE), 32'h1);
    tick(); REQ = 4'b0000; tick();

    // Data change after grant must not affect the write
    set_req(0, 2'd1, 8'h11);
    REQ = 4'b0001;
    tick();
    chk("dc_wdata", 32'(WDATA), 32'h11);
    set_req(0, 2'd1, 8'h22);
    tick();
    chk("dc_wdata_hold", 32'(WDATA), 32'h11);
    chk("dc_bank", 32'(bank[1]), 32'h11);
    REQ = 4'b0000;
    tick();

    // Request dropped before any edge is never granted
    REQ = 4'b0100; #2; REQ = 4'b0000;
    tick();
    chk("drop_we", 32'(WE), 32'h0);
    chk("drop_busy", 32'(BUSY), 32'h0);

    // Request dropped during WRITE: write completes, RELEASE exits next edge
    REQ = 4'b0010;
    tick();
    chk("dw_we", 32'(WE), 32'h1);
    REQ = 4'b0000;
    tick();
    chk("dw_gnt", 32'(GNT), 32'h2);
    tick();
    chk("dw_idle", 32'(GNT), 32'h0);

    chk("we_back_to_back", 32'(we_back_to_back), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
